add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq_pkg.sv | 12 +
 rtl/add_struc.sv | 23 ++
 rtl/add_seq.sv | 128 ++++++++++++
 tb/tb_add_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package add_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_struc.sv
// Structural ripple-carry adder built from full-adder cells.
module add_struc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/add_seq.sv
// Nibble-serial adder: one shared 4-bit ripple slice, LSB slice first,
// carry chained across cycles through r_carry.
module add_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [SLICE_W*NIBBLES-1:0]   a,
  input  logic [SLICE_W*NIBBLES-1:0]   b,
  input  logic                         cin,
  output logic                         busy,
  output logic                         done,
  output logic [SLICE_W*NIBBLES-1:0]   sum,
  output logic                         cout
);

  localparam int unsigned W     = SLICE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic               w_last;

  // Select the current slice of the captured operands.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_slice = r_a[i*SLICE_W +: SLICE_W];
        w_b_slice = r_b[i*SLICE_W +: SLICE_W];
      end
    end
  end

  add_struc #(
    .WIDTH (SLICE_W)
  ) u_slice (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status flags track the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NIBBLES); i++) begin
            if (r_idx == IDX_W'(i)) r_sum[i*SLICE_W +: SLICE_W] <= w_slice_sum;
          end
          r_carry <= w_slice_cout;
          if (w_last) r_cout <= w_slice_cout;
          else        r_idx  <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: cycle-level acceptance model feeding a result scoreboard.
module tb_add_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  always #5 clk = ~clk;

  add_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  logic [W:0] sb[$];
  logic [W:0] m_last;
  int         m_cnt;
  int         n_chk;
  int         n_fail;
  int         n_acc;
  int         n_done;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the model says what busy/done/result must be after it.
  task automatic tick();
    logic       acc;
    logic [W:0] exp;
    acc = !rst && start && (m_cnt == 0);
    exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    @(posedge clk);
    if (rst) begin
      m_cnt  = 0;
      m_last = '0;
      sb.delete();
    end else if (acc) begin
      m_cnt = 1;
      sb.push_back(exp);
      n_acc++;
    end else if (m_cnt != 0) begin
      m_cnt = (m_cnt == int'(N) + 1) ? 0 : m_cnt + 1;
    end
    #1;
    chk("busy", (W+1)'(busy), (W+1)'(m_cnt >= 1 && m_cnt <= int'(N)));
    chk("done", (W+1)'(done), (W+1)'(m_cnt == int'(N) + 1));
    if (m_cnt == int'(N) + 1) begin
      n_done++;
      if (sb.size() == 0) chk("sb_empty", (W+1)'(1), (W+1)'(0));
      else begin
        m_last = sb.pop_front();
        chk("result", {cout, sum}, m_last);
      end
    end else if (m_cnt == 0) begin
      chk("held", {cout, sum}, m_last);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (m_cnt != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", (W+1)'(m_cnt), (W+1)'(0));
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    wait_idle(20);
  endtask

  initial begin
    int guard;
    int acc0;
    int done0;
    sb.delete();
    m_last = '0;
    m_cnt  = 0;
    n_chk  = 0;
    n_fail = 0;
    n_acc  = 0;
    n_done = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_state", {busy, done, cout}, (W+1)'(0));
    chk("reset_sum", (W+1)'(sum), (W+1)'(0));
    tick();

    run_op(16'h1234, 16'h4321, 1'b0);
    chk("sum_5555", {cout, sum}, 17'h0_5555);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    chk("ripple_all", {cout, sum}, 17'h1_0000);
    run_op(16'h0000, 16'h0000, 1'b1);
    chk("cin_only", {cout, sum}, 17'h0_0001);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);
    chk("max_sum", {cout, sum}, 17'h1_FFFF);

    // start held high with operands changing every cycle
    acc0 = n_acc; done0 = n_done;
    start = 1'b1;
    for (int i = 0; i < 6 * int'(N + 2); i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle(20);
    chk("cont_accepts", (W+1)'(n_acc - acc0), (W+1)'(6));
    chk("cont_dones", (W+1)'(n_done - done0), (W+1)'(6));

    // reset in the second RUN cycle aborts the addition
    a = 16'h8888; b = 16'h8888; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", {busy, done, cout}, (W+1)'(0));
    chk("abort_sum", (W+1)'(sum), (W+1)'(0));
    done0 = n_done;
    for (int i = 0; i < int'(N) + 2; i++) tick();
    chk("abort_no_done", (W+1)'(n_done - done0), (W+1)'(0));
    run_op(16'h0F0F, 16'h00F1, 1'b0);
    chk("post_abort", {cout, sum}, 17'h0_1000);

    // random operands, random start, inputs toggling during RUN
    acc0 = n_acc;
    guard = 0;
    while ((n_acc - acc0) < 1000 && guard < 20000) begin
      start = ($urandom_range(0, 3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
      guard++;
    end
    start = 1'b0;
    wait_idle(20);
    chk("rand_count", (W+1)'(n_acc - acc0), (W+1)'(1000));
    chk("sb_drained", (W+1)'(sb.size()), (W+1)'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
